// File: rtl/character_control_grid_if.sv
// character_control_grid_if
// Groups the game-side inputs and renderer/score-side outputs of the player
// controller. The master side (upstream switches, hazard logic, bench) drives
// the i_* requests. The slave side (the controller) drives the o_* status.
//   i_Game_Active       game enable level
//   i_Frog_Up/Dn/Lt/Rt  debounced direction requests
//   i_Has_Collided      collision level from hazard logic
//   o_Frog_X/Y          pixel position of the sprite's top-left corner
//   o_Frog_Col/Row      tile position
//   o_Score, o_Lives    score and remaining lives
//   o_Level_Up          one-cycle pulse when the goal is reached
//   o_Life_Lost         one-cycle pulse when a collision is accepted
//   o_Game_Over         high in GAME_OVER
//   o_Draw_Frog         sprite enable
//   o_State             FSM state code
interface character_control_grid_if #(
  parameter int SCORE_W = 4
);
  logic               i_Game_Active;
  logic               i_Frog_Up;
  logic               i_Frog_Dn;
  logic               i_Frog_Lt;
  logic               i_Frog_Rt;
  logic               i_Has_Collided;
  logic [9:0]         o_Frog_X;
  logic [8:0]         o_Frog_Y;
  logic [4:0]         o_Frog_Col;
  logic [3:0]         o_Frog_Row;
  logic [SCORE_W-1:0] o_Score;
  logic [2:0]         o_Lives;
  logic               o_Level_Up;
  logic               o_Life_Lost;
  logic               o_Game_Over;
  logic               o_Draw_Frog;
  logic [1:0]         o_State;

  modport master (
    output i_Game_Active, i_Frog_Up, i_Frog_Dn, i_Frog_Lt, i_Frog_Rt, i_Has_Collided,
    input  o_Frog_X, o_Frog_Y, o_Frog_Col, o_Frog_Row, o_Score, o_Lives,
           o_Level_Up, o_Life_Lost, o_Game_Over, o_Draw_Frog, o_State
  );

  modport slave (
    input  i_Game_Active, i_Frog_Up, i_Frog_Dn, i_Frog_Lt, i_Frog_Rt, i_Has_Collided,
    output o_Frog_X, o_Frog_Y, o_Frog_Col, o_Frog_Row, o_Score, o_Lives,
           o_Level_Up, o_Life_Lost, o_Game_Over, o_Draw_Frog, o_State
  );
endinterface

// File: rtl/character_control_grid.sv
// character_control_grid
// Player controller for the frogger-style game. It tracks the frog on a tile
// grid and supports hold-to-repeat movement, lives, a respawn phase and game over.
//   i_Clk    system clock
//   i_Rst_N  asynchronous active-low reset
//   bus      character_control_grid_if.slave (requests in, status out)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for i_Game_Active; frog at start, not drawn
// PLAY      | frog drawn, moves on requests, collisions cost a life
// RESPAWN   | frog hidden at start for RESPAWN_CYCLES; inputs ignored
// GAME_OVER | no lives left; score/lives frozen until i_Game_Active drops
module character_control_grid #(
  parameter int TILE_SIZE      = 32,
  parameter int GRID_COLS      = 20,
  parameter int GRID_ROWS      = 15,
  parameter int START_COL      = 10,
  parameter int START_ROW      = 12,
  parameter int HOLD_DELAY     = 6250000,
  parameter int MOVE_DELAY     = 3125000,
  parameter int RESPAWN_CYCLES = 25000000,
  parameter int LIVES_INI      = 3,
  parameter int SCORE_INI      = 0,
  parameter int SCORE_W        = 4
) (
  input logic                     i_Clk,
  input logic                     i_Rst_N,
  character_control_grid_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PLAY      = 2'd1,
    S_RESPAWN   = 2'd2,
    S_GAME_OVER = 2'd3
  } state_t;

  localparam int TSHIFT  = $clog2(TILE_SIZE);
  localparam int TMR_MAX = (HOLD_DELAY > MOVE_DELAY) ? HOLD_DELAY : MOVE_DELAY;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int RSP_W   = $clog2(RESPAWN_CYCLES + 1);

  localparam logic [4:0]         COL_START = 5'(START_COL);
  localparam logic [3:0]         ROW_START = 4'(START_ROW);
  localparam logic [4:0]         COL_MAX   = 5'(GRID_COLS - 1);
  localparam logic [3:0]         ROW_MAX   = 4'(GRID_ROWS - 1);
  localparam logic [TMR_W-1:0]   HOLD_V    = TMR_W'(HOLD_DELAY);
  localparam logic [TMR_W-1:0]   MOVE_V    = TMR_W'(MOVE_DELAY);
  localparam logic [RSP_W-1:0]   RSP_V     = RSP_W'(RESPAWN_CYCLES);
  localparam logic [2:0]         LIVES_V   = 3'(LIVES_INI);
  localparam logic [SCORE_W-1:0] SCORE_V   = SCORE_W'(SCORE_INI);
  localparam logic [9:0]         X_START   = 10'(32'(COL_START) << TSHIFT);
  localparam logic [8:0]         Y_START   = 9'(32'(ROW_START) << TSHIFT);

  state_t             state_q, state_d;
  logic [3:0]         dir_now, dir_dec, dir_prev_q;
  logic               new_req, rep_req;
  logic [4:0]         col_q, col_d;
  logic [3:0]         row_q, row_d;
  logic [9:0]         x_q;
  logic [8:0]         y_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [RSP_W-1:0]   rsp_q, rsp_d;
  logic               level_up_q, level_up_d;
  logic               life_lost_q, life_lost_d;
  logic               game_over_q, draw_q;

  // Only a one-hot request is meaningful; chords and idle both decode to zero.
  assign dir_now = {bus.i_Frog_Up, bus.i_Frog_Dn, bus.i_Frog_Lt, bus.i_Frog_Rt};
  assign dir_dec = $onehot(dir_now) ? dir_now : 4'b0000;
  assign new_req = (dir_dec != 4'b0000) && (dir_dec != dir_prev_q);
  // The repeat step fires on the cycle the timer runs out (1 -> 0). A held
  // request with an idle timer (0) never moves, so a request already held on
  // entry to PLAY needs a fresh edge.
  assign rep_req = (dir_dec != 4'b0000) && (dir_dec == dir_prev_q) && (tmr_q == TMR_W'(1));

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (bus.i_Game_Active) state_d = S_PLAY;
      S_PLAY: begin
        if (!bus.i_Game_Active)      state_d = S_IDLE;
        else if (bus.i_Has_Collided) state_d = (lives_q <= 3'd1) ? S_GAME_OVER : S_RESPAWN;
      end
      S_RESPAWN: begin
        if (!bus.i_Game_Active)      state_d = S_IDLE;
        else if (rsp_q <= RSP_W'(1)) state_d = S_PLAY;
      end
      S_GAME_OVER: if (!bus.i_Game_Active) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    score_d     = score_q;
    lives_d     = lives_q;
    tmr_d       = tmr_q;
    rsp_d       = rsp_q;
    level_up_d  = 1'b0;
    life_lost_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        col_d = COL_START;
        row_d = ROW_START;
        tmr_d = '0;
        rsp_d = '0;
        if (bus.i_Game_Active) begin
          score_d = SCORE_V;
          lives_d = LIVES_V;
        end
      end
      S_PLAY: begin
        if (!bus.i_Game_Active) begin
          col_d = COL_START;
          row_d = ROW_START;
          tmr_d = '0;
        end else if (bus.i_Has_Collided) begin
          // Collision wins over any move or goal in the same cycle.
          col_d       = COL_START;
          row_d       = ROW_START;
          tmr_d       = '0;
          rsp_d       = RSP_V;
          life_lost_d = 1'b1;
          if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
        end else begin
          if (new_req)                   tmr_d = HOLD_V;
          else if (rep_req)              tmr_d = MOVE_V;
          else if (dir_dec != 4'b0000)   tmr_d = (tmr_q != '0) ? tmr_q - TMR_W'(1) : '0;
          else                           tmr_d = '0;
          if (new_req || rep_req) begin
            case (dir_dec)
              4'b1000: begin
                if (row_q == 4'd1) begin
                  // Goal: row 0 is never shown, frog goes straight back to start.
                  col_d      = COL_START;
                  row_d      = ROW_START;
                  level_up_d = 1'b1;
                  if (score_q != '1) score_d = score_q + SCORE_W'(1);
                end else if (row_q != 4'd0) begin
                  row_d = row_q - 4'd1;
                end
              end
              4'b0100: if (row_q != ROW_MAX) row_d = row_q + 4'd1;
              4'b0010: if (col_q != 5'd0)    col_d = col_q - 5'd1;
              4'b0001: if (col_q != COL_MAX) col_d = col_q + 5'd1;
              default: ;
            endcase
          end
        end
      end
      S_RESPAWN: begin
        col_d = COL_START;
        row_d = ROW_START;
        tmr_d = '0;
        if (!bus.i_Game_Active) rsp_d = '0;
        else                    rsp_d = (rsp_q != '0) ? rsp_q - RSP_W'(1) : '0;
      end
      S_GAME_OVER: begin
        tmr_d = '0;
        rsp_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      dir_prev_q  <= 4'b0000;
      col_q       <= COL_START;
      row_q       <= ROW_START;
      x_q         <= X_START;
      y_q         <= Y_START;
      score_q     <= SCORE_V;
      lives_q     <= LIVES_V;
      tmr_q       <= '0;
      rsp_q       <= '0;
      level_up_q  <= 1'b0;
      life_lost_q <= 1'b0;
      game_over_q <= 1'b0;
      draw_q      <= 1'b0;
    end else begin
      dir_prev_q  <= dir_dec;
      col_q       <= col_d;
      row_q       <= row_d;
      x_q         <= 10'(32'(col_d) << TSHIFT);
      y_q         <= 9'(32'(row_d) << TSHIFT);
      score_q     <= score_d;
      lives_q     <= lives_d;
      tmr_q       <= tmr_d;
      rsp_q       <= rsp_d;
      level_up_q  <= level_up_d;
      life_lost_q <= life_lost_d;
      game_over_q <= (state_d == S_GAME_OVER);
      draw_q      <= (state_d == S_PLAY);
    end
  end

  assign bus.o_Frog_X    = x_q;
  assign bus.o_Frog_Y    = y_q;
  assign bus.o_Frog_Col  = col_q;
  assign bus.o_Frog_Row  = row_q;
  assign bus.o_Score     = score_q;
  assign bus.o_Lives     = lives_q;
  assign bus.o_Level_Up  = level_up_q;
  assign bus.o_Life_Lost = life_lost_q;
  assign bus.o_Game_Over = game_over_q;
  assign bus.o_Draw_Frog = draw_q;
  assign bus.o_State     = state_q;

endmodule

// File: doc/character_control_grid.md
Name: character_control_grid

Overview:
- Next-generation player controller for the frogger-style game. It tracks player position on a parametrised tile grid.
- Adds hold-to-repeat movement, a lives counter, a respawn phase and a game-over state, all driven by an explicit FSM.
- Sits between the debounced direction switches / collision detector and the sprite renderer and score display.

Parameters:
- TILE_SIZE, 32, pixel size of one grid tile (power of two).
- GRID_COLS, 20, number of columns; column index range is 0..GRID_COLS-1.
- GRID_ROWS, 15, number of rows; row 0 is the goal row.
- START_COL, 10, spawn column.
- START_ROW, 12, spawn row.
- HOLD_DELAY, 6250000, cycles a direction must be held before auto-repeat starts.
- MOVE_DELAY, 3125000, cycles between auto-repeat steps.
- RESPAWN_CYCLES, 25000000, duration of the respawn phase.
- LIVES_INI, 3, lives at game start (1..7).
- SCORE_INI, 0, score at game start.
- SCORE_W, 4, score width.

Ports:
- i_Clk, in, 1, system clock.
- i_Rst_N, in, 1, reset, asynchronous, active-low.
- i_Game_Active, in, 1, game enable level.
- i_Frog_Up, in, 1, up request. Synchronous, debounced upstream.
- i_Frog_Dn, in, 1, down request.
- i_Frog_Lt, in, 1, left request.
- i_Frog_Rt, in, 1, right request.
- i_Has_Collided, in, 1, collision level from hazard logic.
- o_Frog_X, out, 10, pixel X of tile top-left = col*TILE_SIZE.
- o_Frog_Y, out, 9, pixel Y = row*TILE_SIZE.
- o_Frog_Col, out, 5, current column.
- o_Frog_Row, out, 4, current row.
- o_Score, out, SCORE_W, score.
- o_Lives, out, 3, remaining lives.
- o_Level_Up, out, 1, one-cycle pulse on goal reached.
- o_Life_Lost, out, 1, one-cycle pulse on collision accepted.
- o_Game_Over, out, 1, high in GAME_OVER state.
- o_Draw_Frog, out, 1, sprite enable.
- o_State, out, 2, FSM state: 0 IDLE, 1 PLAY, 2 RESPAWN, 3 GAME_OVER.

Behaviour:
- Reset (async, i_Rst_N=0):
  - State IDLE; col/row = START_COL/START_ROW; X/Y consistent with them.
  - Score = SCORE_INI; lives = LIVES_INI.
  - All pulses 0; o_Game_Over=0; o_Draw_Frog=0; timers 0.
- All outputs are registered. A move is visible on o_Frog_* one cycle after the qualifying input edge.
- Direction decode: a direction is valid only when exactly one of the four inputs is high (one-hot). Zero or more than one high means no request. Previous decoded vector is registered.
- IDLE:
  - Outputs held at start values; o_Draw_Frog=0.
  - i_Game_Active=1 -> PLAY; score and lives reloaded, position set to start.
- PLAY:
  - o_Draw_Frog=1.
  - A new valid request (decoded vector changed to a valid one) moves immediately and loads the timer with HOLD_DELAY.
  - While the same request stays valid and the timer reaches 0: move, reload with MOVE_DELAY.
  - Request released or changed: timer is cleared.
  - Left at col 0, right at col GRID_COLS-1, down at row GRID_ROWS-1: ignored, no wrap. The timer still reloads.
  - Up at row 1 (entering row 0) is a goal:
    - score+1, saturating at all-ones; o_Level_Up pulse; position reset to start.
    - No row-0 position is ever output.
  - Collision (i_Has_Collided=1) has priority over any move in the same cycle:
    - lives-1, o_Life_Lost pulse, position to start.
    - If the new lives value is 0: -> GAME_OVER. Otherwise -> RESPAWN with counter = RESPAWN_CYCLES.
- RESPAWN:
  - Inputs and collisions are ignored; position held at start; o_Draw_Frog=0.
  - Counter reaches 0 -> PLAY. Direction inputs still held on entry to PLAY do not move; a fresh edge is required.
- GAME_OVER:
  - o_Game_Over=1, o_Draw_Frog=0; score and lives frozen for display.
  - i_Game_Active=0 -> IDLE.
- i_Game_Active=0 in PLAY or RESPAWN -> IDLE next cycle (abort). Score and lives are not reloaded until the next start.
- Goal and collision in the same cycle: collision wins; no score, no o_Level_Up.
- Widths: coordinate multiply is a shift (TILE_SIZE power of two); X/Y are truncated to port width.

Test Plan:
- Reset, then i_Game_Active=1 with TILE_SIZE=32, START=(10,12) -> state PLAY, X=320, Y=384, o_Lives=3, o_Score=0, o_Draw_Frog=1.
- HOLD_DELAY=8, MOVE_DELAY=4; hold i_Frog_Rt 20 cycles -> col steps 10→11 at cycle 1, →12 at cycle 9, →13 at cycle 13, →14 at cycle 17.
- Up and Lt high together for 10 cycles -> no movement. Lt alone at col 0 -> col stays 0.
- Start at row 12, 12 separate up presses -> 12th press gives o_Level_Up one-cycle pulse, score 1, row 12. At score 15 (SCORE_W=4) another goal keeps score at 15.
- RESPAWN_CYCLES=5; collision at col 13 -> o_Life_Lost pulse, lives 2, state RESPAWN, X=320, draw 0. Collision pulse during respawn -> lives stays 2. Return to PLAY after 5 cycles.
- Three collisions -> lives 0, o_Game_Over=1. Drop i_Game_Active -> IDLE. Re-raise -> lives 3, score 0. Assert i_Rst_N=0 mid-move -> immediate IDLE/start values with no clock edge.
